pmem_loader: RTL and testbench
==============================

PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 Parameter AW, default 9, SHALL set the program memory word-address width.
REQ-002 Parameter MAX_WORDS, default 512, SHALL set the largest accepted image in 16-bit words.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  input  1  SHALL request a new load when sampled high in IDLE, DONE or ERR.
REQ-006 in_data  input  8  SHALL carry the serial image byte.
REQ-007 in_valid  input  1  SHALL flag in_data as valid.
REQ-008 in_ready  output  1  SHALL flag that the loader accepts a byte this cycle.
REQ-009 wr_addr  output  AW  SHALL carry the program memory word address.
REQ-010 wr_data  output  16  SHALL carry the program memory word, {high byte, low byte}.
REQ-011 wr_en  output  1  SHALL be the single-cycle program memory write strobe.
REQ-012 cpu_hold  output  1  SHALL drive the CPU/fetch stall input.
REQ-013 done  output  1  SHALL flag a successful load.
REQ-014 error  output  1  SHALL flag a failed load.

Function
REQ-015 A byte SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-016 Stream format SHALL be: count low byte, count high byte (N words), then N words, each low byte first, then one checksum byte.
REQ-017 The states SHALL be IDLE, CNT_LO, CNT_HI, W_LO, W_HI, WRITE, CSUM, DONE and ERR.
REQ-018 in_ready SHALL be 1 in CNT_LO, CNT_HI, W_LO, W_HI and CSUM only; it is 0 in all other states, including WRITE.
REQ-019 start SHALL move IDLE, DONE or ERR to CNT_LO; it clears done and error, zeroes the address counter and zeroes the running sum.
REQ-020 start SHALL be ignored in every other state.
REQ-021 On an accepted byte, state SHALL advance CNT_LO->CNT_HI, and W_LO->W_HI.
REQ-022 On an accepted byte in CNT_HI: if N>MAX_WORDS the next state SHALL be ERR; if N=0 it SHALL be CSUM; otherwise W_LO.
REQ-023 On an accepted byte in W_HI the next state SHALL be WRITE.
REQ-024 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr equal to the counter and wr_data equal to {hi,lo}.
REQ-025 WRITE SHALL take exactly one cycle; in that cycle the counter increments and the remaining count decrements.
REQ-026 After WRITE the next state SHALL be CSUM when the remaining count reaches 0, else W_LO.
REQ-027 wr_en SHALL be 0 in every state except WRITE.
REQ-028 The running sum SHALL be an 8-bit sum, mod 256, of every accepted byte, including the count bytes and the checksum byte.
REQ-029 On the accepted CSUM byte, the next state SHALL be DONE if the final sum is 0x00, else ERR.
REQ-030 done SHALL be 1 exactly when in DONE, and error exactly when in ERR; both hold until start or RST.
REQ-031 cpu_hold SHALL be 1 in every state except DONE; the CPU therefore stays stalled after reset and after an error.
REQ-032 Minimum throughput SHALL be 3 cycles per word: W_LO, W_HI, WRITE.
REQ-033 in_valid low SHALL stall the FSM in place with no state or sum change.

Reset
REQ-034 RST SHALL, on the rising edge it is sampled high, force IDLE, counter 0, sum 0, and remaining count 0, regardless of state.
REQ-035 During and after that reset edge: wr_en=0, in_ready=0, done=0, error=0, cpu_hold=1, wr_addr=0, wr_data=0.
REQ-036 A reset in WRITE SHALL suppress that write; no partial word is ever written.

Verification
REQ-037 Bench SHALL cover: start, then 02 00 0C 94 00 00 5E -> writes addr0=0x940C, addr1=0x0000; done=1 and cpu_hold=0 one cycle after 5E is accepted.
REQ-038 Bench SHALL cover: same stream with checksum 5F -> both writes occur; error=1, done=0, cpu_hold=1.
REQ-039 Bench SHALL cover: start, then 00 00 00 -> no wr_en pulse; done=1.
REQ-040 Bench SHALL cover: start, then 01 02 (N=513) -> ERR on the next cycle; no wr_en pulse; later bytes not accepted.
REQ-041 Bench SHALL cover: in_valid toggled randomly on a 3-word image -> identical writes; in_ready=0 on every WRITE cycle.
REQ-042 Bench SHALL cover: RST pulsed after the 1st of 3 words -> IDLE and outputs at reset values; a fresh start and a full image then load from addr0.

Source files
------------

// File: rtl/pmem_loader.sv
// pmem_loader: loads a serial byte image (count, words, checksum) into program memory while holding the CPU.
module pmem_loader #(
  parameter int AW = 9,
  parameter int MAX_WORDS = 512
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          wr_en,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);
  typedef enum logic [3:0] {IDLE, CNT_LO, CNT_HI, W_LO, W_HI, WRITE, CSUM, DONE, ERR} state_t;
  state_t state, next;
  logic [AW-1:0] addr;
  logic [7:0] sum, lo, hi, sum_next;
  logic [15:0] rem, n;
  logic acc, restart;
  // Outputs are gated by RST so the reset cycle itself already shows idle values and drops any pending write.
  always_comb begin
    in_ready = !RST && (state inside {CNT_LO, CNT_HI, W_LO, W_HI, CSUM});
    acc = in_ready && in_valid;
    restart = start && (state inside {IDLE, DONE, ERR});
    n = {in_data, rem[7:0]};
    sum_next = sum + in_data;
    wr_en = !RST && state == WRITE;
    wr_addr = RST ? '0 : addr;
    wr_data = wr_en ? {hi, lo} : 16'h0;
    done = !RST && state == DONE;
    error = !RST && state == ERR;
    cpu_hold = RST || state != DONE;
    next = state;
    case (state)
      IDLE, DONE, ERR: next = start ? CNT_LO : state;
      CNT_LO: next = acc ? CNT_HI : state;
      CNT_HI: next = !acc ? state : n > 16'(MAX_WORDS) ? ERR : n == 16'h0 ? CSUM : W_LO;
      W_LO: next = acc ? W_HI : state;
      W_HI: next = acc ? WRITE : state;
      WRITE: next = rem == 16'h1 ? CSUM : W_LO;
      CSUM: next = !acc ? state : sum_next == 8'h0 ? DONE : ERR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      addr <= '0;
      sum <= 8'h0;
      rem <= 16'h0;
      lo <= 8'h0;
      hi <= 8'h0;
    end else begin
      state <= next;
      if (restart) begin
        addr <= '0;
        sum <= 8'h0;
      end
      if (acc) sum <= sum_next;
      if (acc && state == CNT_LO) rem[7:0] <= in_data;
      if (acc && state == CNT_HI) rem[15:8] <= in_data;
      if (acc && state == W_LO) lo <= in_data;
      if (acc && state == W_HI) hi <= in_data;
      if (state == WRITE) begin
        addr <= addr + 1'b1;
        rem <= rem - 16'h1;
      end
    end
  end
endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: scoreboard bench; expected writes queued as images are sent, popped on each wr_en.
module tb_pmem_loader;
  logic CLK = 0, RST = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, wr_en, cpu_hold, done, error;
  logic [8:0] wr_addr;
  logic [15:0] wr_data;
  int n_cmp = 0, n_bad = 0, n_wr = 0;
  logic [24:0] exp_q[$];
  logic [15:0] img[0:7];

  pmem_loader dut (.CLK(CLK), .RST(RST), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .cpu_hold(cpu_hold), .done(done), .error(error));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) if (wr_en) begin
    n_wr++;
    check("wr_ready_low", in_ready, 0);
    if (exp_q.size() == 0) check("wr_unexpected", {7'h0, wr_addr, wr_data}, 0);
    else begin
      logic [24:0] e;
      e = exp_q.pop_front();
      check("wr_addr", wr_addr, e[24:16]);
      check("wr_data", wr_data, e[15:0]);
    end
  end

  task automatic send(input logic [7:0] b, input bit rnd);
    int t = 0;
    if (rnd) while ($urandom_range(1) == 1) begin
      in_valid = 0;
      @(negedge CLK);
    end
    in_data = b;
    in_valid = 1;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) check("ready_timeout", t, 0);
    @(negedge CLK);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge CLK);
    start = 0;
  endtask

  task automatic send_image(input int n, input bit rnd, input logic [7:0] cs_adj);
    logic [7:0] s;
    s = 8'(n) + 8'(n >> 8);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({9'(i), img[i]});
      s = s + img[i][7:0] + img[i][15:8];
    end
    send(8'(n), rnd);
    send(8'(n >> 8), rnd);
    for (int i = 0; i < n; i++) begin
      send(img[i][7:0], rnd);
      send(img[i][15:8], rnd);
    end
    send(8'(-s) + cs_adj, rnd);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_hold"}, cpu_hold, 1);
    check({tag, "_addr"}, wr_addr, 0);
    check({tag, "_data"}, wr_data, 0);
  endtask

  initial begin
    int w0;
    repeat (2) @(negedge CLK);
    check_idle("rst");
    RST = 0;
    @(negedge CLK);
    check_idle("idle");
    // Two-word image, good checksum (0x5E)
    img[0] = 16'h940C; img[1] = 16'h0000;
    w0 = n_wr;
    pulse_start();
    send_image(2, 0, 0);
    check("t1_done", done, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_error", error, 0);
    check("t1_writes", n_wr - w0, 2);
    // Same image, checksum 0x5F
    w0 = n_wr;
    pulse_start();
    send_image(2, 0, 1);
    check("t2_error", error, 1);
    check("t2_done", done, 0);
    check("t2_hold", cpu_hold, 1);
    check("t2_writes", n_wr - w0, 2);
    // Empty image
    w0 = n_wr;
    pulse_start();
    send_image(0, 0, 0);
    check("t3_done", done, 1);
    check("t3_writes", n_wr - w0, 0);
    // Oversized count N=513
    w0 = n_wr;
    pulse_start();
    send(8'h01, 0);
    send(8'h02, 0);
    check("t4_error", error, 1);
    in_valid = 1;
    in_data = 8'hAA;
    repeat (4) @(negedge CLK);
    check("t4_ready", in_ready, 0);
    check("t4_error_hold", error, 1);
    in_valid = 0;
    check("t4_writes", n_wr - w0, 0);
    // Three words with random in_valid gaps
    img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h00FF;
    w0 = n_wr;
    pulse_start();
    send_image(3, 1, 0);
    check("t5_done", done, 1);
    check("t5_writes", n_wr - w0, 3);
    // Reset after the first of three words, then a fresh full load
    pulse_start();
    exp_q.push_back({9'h0, 16'h1234});
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    @(negedge CLK);
    RST = 1;
    #1 check_idle("t6_during");
    @(negedge CLK);
    RST = 0;
    check_idle("t6_after");
    @(negedge CLK);
    check("t6_still_idle", in_ready, 0);
    w0 = n_wr;
    img[0] = 16'h5A5A; img[1] = 16'h0001; img[2] = 16'hFFFF;
    pulse_start();
    send_image(3, 0, 0);
    check("t6_done", done, 1);
    check("t6_writes", n_wr - w0, 3);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
